// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a ready-handshaked data-RAM port,
// stalls upstream until completion and registers the write-back triple for WB.
module mem_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [3:0]                mem_op_in,
  input  logic [DATA_WIDTH-1:0]     result_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  input  logic                      write_reg_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_addr_in,
  output logic                      ram_en,
  output logic                      ram_write_en,
  output logic [3:0]                ram_sel,
  output logic [DATA_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_write_data,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  input  logic                      ram_ready,
  output logic                      stall_req,
  output logic                      addr_error,
  output logic                      bus_error,
  output logic [DATA_WIDTH-1:0]     result_out,
  output logic                      write_reg_en_out,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr_out
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state;
  logic [CW-1:0]             wait_cnt;
  logic [3:0]                op_q;
  logic [DATA_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     sdata_q;
  logic                      wen_q;
  logic [REG_ADDR_WIDTH-1:0] waddr_q;

  logic is_mem, misaligned, accept, busy, timeout;

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         return 4'b1111;
      default:              return 4'b0000;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [3:0] op,
                                                        input logic [DATA_WIDTH-1:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Little-endian lane extraction followed by sign or zero extension.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [3:0] op,
                                                        input logic [1:0] a,
                                                        input logic [DATA_WIDTH-1:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   return DATA_WIDTH'(b);
      OP_LBU:  return {24'd0, b};
      OP_LH:   return DATA_WIDTH'(h);
      OP_LHU:  return {16'd0, h};
      default: return d;
    endcase
  endfunction

  always_comb begin
    is_mem     = (mem_op_in >= OP_LB) && (mem_op_in <= OP_SW);
    misaligned = (((mem_op_in == OP_LH) || (mem_op_in == OP_LHU) || (mem_op_in == OP_SH))
                  && result_in[0])
               || (((mem_op_in == OP_LW) || (mem_op_in == OP_SW)) && (result_in[1:0] != 2'b00));
    busy       = (state == BUSY);
    accept     = !busy && valid_in && is_mem && !misaligned;
    timeout    = busy && !ram_ready && (wait_cnt == LAST_WAIT);
    stall_req  = accept || (busy && !ram_ready && !timeout);
    ram_en         = busy;
    ram_write_en   = busy && op_is_store(op_q);
    ram_sel        = busy ? lane_sel(op_q, addr_q[1:0]) : 4'b0000;
    ram_addr       = busy ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    ram_write_data = busy ? store_lanes(op_q, sdata_q) : '0;
  end

  // Capture stage: access parameters held for the whole BUSY period.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= mem_op_in;
      addr_q  <= result_in;
      sdata_q <= store_data_in;
      wen_q   <= write_reg_en_in;
      waddr_q <= write_reg_addr_in;
    end
  end

  // Writeback stage: registered triple and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      result_out         <= '0;
      write_reg_en_out   <= 1'b0;
      write_reg_addr_out <= '0;
      addr_error         <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt           <= '0;
          result_out         <= result_in;
          write_reg_addr_out <= write_reg_addr_in;
          write_reg_en_out   <= valid_in && write_reg_en_in && !is_mem;
          addr_error         <= valid_in && is_mem && misaligned;
          if (accept) state <= BUSY;
        end
        BUSY: begin
          if (ram_ready) begin
            state              <= IDLE;
            wait_cnt           <= '0;
            result_out         <= op_is_store(op_q) ? addr_q
                                                    : load_extend(op_q, addr_q[1:0], ram_read_data);
            write_reg_en_out   <= wen_q && !op_is_store(op_q);
            write_reg_addr_out <= waddr_q;
          end else if (timeout) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            bus_error        <= 1'b1;
            write_reg_en_out <= 1'b0;
          end else begin
            wait_cnt         <= wait_cnt + 1'b1;
            write_reg_en_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, misalignment, timeout, reset
// abandonment and a back-to-back access, against hand-computed values.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [3:0]  mem_op_in;
  logic [31:0] result_in, store_data_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        ram_en, ram_write_en;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_ready;
  logic        stall_req, addr_error, bus_error;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;

  int total = 0;
  int bad   = 0;
  int n;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_op_in(mem_op_in),
    .result_in(result_in), .store_data_in(store_data_in),
    .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_sel(ram_sel),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .ram_ready(ram_ready),
    .stall_req(stall_req), .addr_error(addr_error), .bus_error(bus_error),
    .result_out(result_out), .write_reg_en_out(write_reg_en_out),
    .write_reg_addr_out(write_reg_addr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa);
    valid_in = 1'b1; mem_op_in = op; result_in = a; store_data_in = sd;
    write_reg_en_in = we; write_reg_addr_in = wa;
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; mem_op_in = 4'd0; result_in = '0; store_data_in = '0;
    write_reg_en_in = 1'b0; write_reg_addr_in = '0; ram_read_data = '0; ram_ready = 1'b0;
    tick(); tick();
    chk("rst_result", result_out, 32'd0);
    chk("rst_we", {31'd0, write_reg_en_out}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b0;

    // non-memory op, latency 1
    issue(4'd0, 32'h0000_1234, 32'd0, 1'b1, 5'd5);
    chk("nop_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("nop_result", result_out, 32'h0000_1234);
    chk("nop_we", {31'd0, write_reg_en_out}, 32'd1);
    chk("nop_wa", {27'd0, write_reg_addr_out}, 32'd5);

    // LB at 0x103, ready on second BUSY cycle
    issue(4'd1, 32'h0000_0103, 32'd0, 1'b1, 5'd7);
    chk("lb_stall0", {31'd0, stall_req}, 32'd1);
    chk("lb_noram0", {31'd0, ram_en}, 32'd0);
    tick();
    chk("lb_stall1", {31'd0, stall_req}, 32'd1);
    chk("lb_ram_en", {31'd0, ram_en}, 32'd1);
    chk("lb_addr", ram_addr, 32'h0000_0100);
    chk("lb_sel", {28'd0, ram_sel}, 32'h8);
    chk("lb_wen", {31'd0, ram_write_en}, 32'd0);
    chk("lb_bubble", {31'd0, write_reg_en_out}, 32'd0);
    tick();
    ram_ready = 1'b1; ram_read_data = 32'h80FF_0000; valid_in = 1'b0; #1;
    chk("lb_stall2", {31'd0, stall_req}, 32'd0);
    tick();
    ram_ready = 1'b0;
    chk("lb_result", result_out, 32'hFFFF_FF80);
    chk("lb_we", {31'd0, write_reg_en_out}, 32'd1);
    chk("lb_wa", {27'd0, write_reg_addr_out}, 32'd7);
    chk("lb_idle", {31'd0, ram_en}, 32'd0);

    // SH at 0x202, ready on first BUSY cycle
    issue(4'd7, 32'h0000_0202, 32'h0000_ABCD, 1'b1, 5'd9);
    tick();
    valid_in = 1'b0; ram_ready = 1'b1; #1;
    chk("sh_sel", {28'd0, ram_sel}, 32'hC);
    chk("sh_wdata", ram_write_data, 32'hABCD_ABCD);
    chk("sh_wen", {31'd0, ram_write_en}, 32'd1);
    chk("sh_addr", ram_addr, 32'h0000_0200);
    chk("sh_stall", {31'd0, stall_req}, 32'd0);
    tick();
    ram_ready = 1'b0;
    chk("sh_we", {31'd0, write_reg_en_out}, 32'd0);
    chk("sh_result", result_out, 32'h0000_0202);

    // misaligned LW
    issue(4'd5, 32'h0000_0103, 32'd0, 1'b1, 5'd2);
    chk("mis_stall", {31'd0, stall_req}, 32'd0);
    tick();
    valid_in = 1'b0; #1;
    chk("mis_aerr", {31'd0, addr_error}, 32'd1);
    chk("mis_we", {31'd0, write_reg_en_out}, 32'd0);
    chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
    tick();
    chk("mis_pulse", {31'd0, addr_error}, 32'd0);

    // LW timeout with ram_ready held low
    issue(4'd5, 32'h0000_0040, 32'd0, 1'b1, 5'd3);
    tick();
    valid_in = 1'b0; #1;
    n = 0;
    while (ram_en && n < 40) begin
      n++;
      if (n == 16) chk("to_last_stall", {31'd0, stall_req}, 32'd0);
      else chk("to_stall", {31'd0, stall_req}, 32'd1);
      tick();
    end
    chk("to_cycles", n, 32'd16);
    chk("to_berr", {31'd0, bus_error}, 32'd1);
    chk("to_we", {31'd0, write_reg_en_out}, 32'd0);
    chk("to_stall_rel", {31'd0, stall_req}, 32'd0);
    tick();
    chk("to_pulse", {31'd0, bus_error}, 32'd0);

    // reset in the middle of BUSY abandons the access
    issue(4'd5, 32'h0000_0080, 32'd0, 1'b1, 5'd3);
    tick();
    valid_in = 1'b0; rst = 1'b1; ram_ready = 1'b1; ram_read_data = 32'h1234_5678; #1;
    tick();
    rst = 1'b0; ram_ready = 1'b0; #1;
    chk("mr_result", result_out, 32'd0);
    chk("mr_we", {31'd0, write_reg_en_out}, 32'd0);
    chk("mr_ram_en", {31'd0, ram_en}, 32'd0);
    chk("mr_stall", {31'd0, stall_req}, 32'd0);

    // LHU at 0x10 after reset, then back-to-back SB at 0x301
    issue(4'd4, 32'h0000_0010, 32'd0, 1'b1, 5'd4);
    tick();
    valid_in = 1'b0; ram_ready = 1'b1; ram_read_data = 32'h0000_8001; #1;
    chk("lhu_sel", {28'd0, ram_sel}, 32'h3);
    tick();
    ram_ready = 1'b0;
    chk("lhu_result", result_out, 32'h0000_8001);
    chk("lhu_we", {31'd0, write_reg_en_out}, 32'd1);
    chk("lhu_wa", {27'd0, write_reg_addr_out}, 32'd4);
    issue(4'd6, 32'h0000_0301, 32'h0000_005A, 1'b0, 5'd0);
    chk("sb_stall", {31'd0, stall_req}, 32'd1);
    tick();
    valid_in = 1'b0; ram_ready = 1'b1; #1;
    chk("sb_sel", {28'd0, ram_sel}, 32'h2);
    chk("sb_wdata", ram_write_data, 32'h5A5A_5A5A);
    chk("sb_addr", ram_addr, 32'h0000_0300);
    tick();
    ram_ready = 1'b0;
    chk("sb_we", {31'd0, write_reg_en_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline MEM stage, directly upstream of WB.
- Takes the EX/MEM result and executes loads and stores over a ready-handshaked data-RAM port, stalling the pipeline until the access completes.
- Sign/zero-extends load data, generates store byte selects, and flags misaligned or timed-out accesses.
- Registers the write-back triple (result, write enable, register address) consumed by WB.

Parameters:
- DATA_WIDTH, 32, data/address width; fixed at 32, byte-lane logic assumes 4 lanes.
- REG_ADDR_WIDTH, 5, register-file address width.
- MAX_WAIT, 16, cycles in BUSY without ram_ready before a bus error is raised.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  EX/MEM holds a valid instruction.
- mem_op_in  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
- result_in  in  32  ALU result; the effective address for memory ops.
- store_data_in  in  32  rt value for stores.
- write_reg_en_in  in  1  destination write enable.
- write_reg_addr_in  in  5  destination register.
- ram_en  out  1  access request.
- ram_write_en  out  1  1 = store.
- ram_sel  out  4  byte-lane enables; bit i = byte [8i+7:8i].
- ram_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- ram_write_data  out  32  store data replicated to the selected lanes.
- ram_read_data  in  32  load data, valid when ram_ready is high.
- ram_ready  in  1  access complete this cycle.
- stall_req  out  1  upstream must hold EX/MEM contents.
- addr_error  out  1  one-cycle pulse on a misaligned access.
- bus_error  out  1  one-cycle pulse on a timeout.
- result_out  out  32  to WB.
- write_reg_en_out  out  1  to WB.
- write_reg_addr_out  out  5  to WB.

Behaviour:
- Reset: synchronous, active-high on rst, sampled at the clk rising edge. All outputs go to 0, state goes to IDLE, the wait counter clears. rst overrides any in-flight access; the access is abandoned and no writeback is produced.
- FSM states: IDLE and BUSY.
- IDLE, valid_in=0 or op NONE: next cycle result_out=result_in, write_reg_en_out=write_reg_en_in&valid_in, write_reg_addr_out=write_reg_addr_in. Latency is 1; stall_req=0.
- IDLE, memory op with alignment violated (halfword addr[0]!=0; word addr[1:0]!=0):
  - no RAM access; addr_error pulses next cycle;
  - write_reg_en_out=0 next cycle; stall_req=0.
- IDLE, aligned memory op:
  - stall_req=1 combinationally in this cycle;
  - capture op, address, store data and destination into internal registers; go to BUSY.
  - write_reg_en_out=0 next cycle (bubble).
- BUSY outputs:
  - ram_en=1 and all ram_* outputs are driven from the captured registers, stable for the whole state.
  - stall_req = ~ram_ready.
  - The wait counter increments each cycle.
- BUSY, ram_ready=1:
  - Load: extract the byte/half at addr[1:0] (little-endian; lane = addr[1:0], halfword lane = addr[1]). Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Store: result_out = captured address; write_reg_en_out = 0.
  - Outputs are registered next cycle; return to IDLE; the counter clears.
- BUSY, counter reaches MAX_WAIT-1 without ram_ready:
  - drop ram_en; bus_error pulses next cycle;
  - write_reg_en_out=0; return to IDLE; stall_req=0 that cycle.
- Store encoding:
  - SB: ram_sel = 1<<addr[1:0], data = {4{b}}.
  - SH: ram_sel = addr[1] ? 4'b1100 : 4'b0011, data = {2{h}}.
  - SW: ram_sel = 4'b1111.
- Load encoding: ram_sel = the lanes read; ram_write_en=0.
- Inputs are ignored while in BUSY (upstream is held).
- Minimum memory-op latency: accept at T, ram_ready at T+1, WB sees the result at T+2.
- A back-to-back memory op accepted in the IDLE cycle right after completion is legal.

Test Plan:
- Non-memory op: result_in=0x0000_1234, we=1, addr=5 -> next cycle result_out=0x1234, write_reg_en_out=1, write_reg_addr_out=5, stall_req=0.
- LB at 0x100 +3, ram_read_data=0x80FF_0000 with 2-cycle ready:
  - stall_req high 2 cycles; ram_addr=0x100, ram_sel=4'b1000;
  - result_out=0xFFFF_FF80, written to rd.
- SH at 0x202, store_data=0xABCD, ready after 1 cycle -> ram_sel=4'b1100, ram_write_data=0xABCD_ABCD, ram_write_en=1, write_reg_en_out=0.
- LW at 0x103 -> no ram_en, addr_error pulse, write_reg_en_out=0, stall_req never asserted.
- LW with ram_ready held low -> ram_en for exactly 16 cycles, bus_error pulse, IDLE, stall released.
- rst asserted mid-BUSY -> next cycle all outputs 0, ram_en=0, no writeback; a subsequent LHU at 0x10 with data 0x0000_8001 yields 0x0000_8001.
